// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared constants for the sequential encoder: FSM state
//                encoding and the default code width.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // FSM state encoding (1-bit, legacy-compatible constants)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Default code width; request vector width is 2**DEF_OUT_W
  localparam int DEF_OUT_W = 2;

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/encoder_pri.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pri
//  Description : Combinational priority encoder. Returns the index of the
//                selected set bit, a one-hot mask of that bit, and a flag
//                telling whether exactly one bit of the vector is set.
//                Selection order: lowest set bit first by default; highest
//                set bit first when ENCODER_SEQ_MSB_FIRST_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_pri #(
  parameter int OUT_W = encoder_pkg::DEF_OUT_W
) (
  input  logic [(1<<OUT_W)-1:0] vec,
  output logic [OUT_W-1:0]      idx,
  output logic [(1<<OUT_W)-1:0] onehot_mask,
  output logic                  single
);

  localparam int IN_W = 1 << OUT_W;

  logic [IN_W-1:0] w_vec_minus_one;

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign w_vec_minus_one = vec - IN_W'(1);
  assign single          = (vec != '0) && ((vec & w_vec_minus_one) == '0);

  // Priority selection: the last match in the scan wins, so the scan runs
  // from the lowest-priority end towards the highest-priority end.
  always_comb begin
    idx         = '0;
    onehot_mask = '0;
`ifdef ENCODER_SEQ_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        idx            = OUT_W'(i);
        onehot_mask    = '0;
        onehot_mask[i] = 1'b1;
      end
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx            = OUT_W'(i);
        onehot_mask    = '0;
        onehot_mask[i] = 1'b1;
      end
    end
`endif
  end

endmodule : encoder_pri
`default_nettype wire

// File: rtl/encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_seq
//  Description : Sequential encoder. Accepts a multi-hot request vector over
//                a valid/ready handshake and emits the binary index of every
//                set bit, one code per accepted output beat. An all-zero
//                vector is accepted and reported by a one-cycle 'zero' pulse.
//                Macro ENCODER_SEQ_MSB_FIRST_EN selects descending emission
//                order (default: ascending). IN_W must equal 2**OUT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_seq
  import encoder_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int IN_W  = 1 << OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             zero
);

  logic [0:0]      r_state;
  logic [IN_W-1:0] r_pending;
  logic            r_zero;

  logic [OUT_W-1:0] w_idx;
  logic [IN_W-1:0]  w_mask;
  logic             w_single;

  // Selects the next code out of the bits still pending.
  encoder_pri #(
    .OUT_W (OUT_W)
  ) u_pri (
    .vec         (r_pending),
    .idx         (w_idx),
    .onehot_mask (w_mask),
    .single      (w_single)
  );

  // Handshake outputs depend on state/registers only, never on the
  // incoming valid/ready, so no combinational path crosses the block.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_EMIT);
  assign out       = w_idx;
  assign last      = (r_state == ST_EMIT) && w_single;
  assign zero      = r_zero;

  // FSM, pending-bit register and zero-vector pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in != '0) begin
              r_pending <= in;
              r_state   <= ST_EMIT;
            end else begin
              r_zero <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (w_single) begin
              // Final code consumed: return with an empty pending set so
              // 'out' and 'last' read as zero while idle.
              r_pending <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_pending <= r_pending & ~w_mask;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= '0;
        end
      endcase
    end
  end

endmodule : encoder_seq
`default_nettype wire

// File: tb/tb_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_seq
//  Description : Directed self-checking bench for encoder_seq (OUT_W=2).
//                Expected emission order follows ENCODER_SEQ_MSB_FIRST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_seq;

  logic       clk;
  logic       rst;
  logic [3:0] tb_in;
  logic       tb_in_valid;
  logic       tb_in_ready;
  logic [1:0] tb_out;
  logic       tb_out_valid;
  logic       tb_out_ready;
  logic       tb_last;
  logic       tb_zero;

  int n_vec;
  int n_miscmp;

  encoder_seq #(
    .OUT_W (2),
    .IN_W  (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in        (tb_in),
    .in_valid  (tb_in_valid),
    .in_ready  (tb_in_ready),
    .out       (tb_out),
    .out_valid (tb_out_valid),
    .out_ready (tb_out_ready),
    .last      (tb_last),
    .zero      (tb_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected code sequences for each build.
`ifdef ENCODER_SEQ_MSB_FIRST_EN
  localparam logic [1:0] MH_C0 = 2'd3, MH_C1 = 2'd1, MH_C2 = 2'd0;  // 1011
  localparam logic [1:0] BP_C0 = 2'd2, BP_C1 = 2'd1;                 // 0110
  localparam logic [1:0] BZ_C0 = 2'd2, BZ_C1 = 2'd0;                 // 0101
`else
  localparam logic [1:0] MH_C0 = 2'd0, MH_C1 = 2'd1, MH_C2 = 2'd3;
  localparam logic [1:0] BP_C0 = 2'd1, BP_C1 = 2'd2;
  localparam logic [1:0] BZ_C0 = 2'd0, BZ_C1 = 2'd2;
`endif

  initial begin
    logic [1:0] mh_codes [3];
    mh_codes[0] = MH_C0;
    mh_codes[1] = MH_C1;
    mh_codes[2] = MH_C2;
    n_vec        = 0;
    n_miscmp     = 0;
    rst          = 1'b1;
    tb_in        = 4'b0000;
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_in_ready",  32'(tb_in_ready),  32'd1);
    chk("rst_out_valid", 32'(tb_out_valid), 32'd0);
    chk("rst_out",       32'(tb_out),       32'd0);
    chk("rst_last",      32'(tb_last),      32'd0);
    chk("rst_zero",      32'(tb_zero),      32'd0);
    rst = 1'b0;
    step();

    // Single bit 1000
    tb_in = 4'b1000; tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    step();
    tb_in_valid = 1'b0;
    chk("single_valid", 32'(tb_out_valid), 32'd1);
    chk("single_out",   32'(tb_out),       32'd3);
    chk("single_last",  32'(tb_last),      32'd1);
    chk("single_busy",  32'(tb_in_ready),  32'd0);
    step();
    chk("single_done_valid", 32'(tb_out_valid), 32'd0);
    chk("single_done_ready", 32'(tb_in_ready),  32'd1);

    // Multi-hot 1011
    tb_in = 4'b1011; tb_in_valid = 1'b1;
    step();
    tb_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mh_valid", 32'(tb_out_valid), 32'd1);
      chk("mh_out",   32'(tb_out),       32'(mh_codes[k]));
      chk("mh_last",  32'(tb_last),      (k == 2) ? 32'd1 : 32'd0);
      chk("mh_in_ready", 32'(tb_in_ready), 32'd0);
      step();
    end
    chk("mh_done_valid", 32'(tb_out_valid), 32'd0);
    chk("mh_done_ready", 32'(tb_in_ready),  32'd1);

    // Zero vector
    tb_in = 4'b0000; tb_in_valid = 1'b1;
    step();
    tb_in_valid = 1'b0;
    chk("zero_pulse",    32'(tb_zero),      32'd1);
    chk("zero_valid",    32'(tb_out_valid), 32'd0);
    chk("zero_in_ready", 32'(tb_in_ready),  32'd1);
    step();
    chk("zero_pulse_end", 32'(tb_zero),      32'd0);
    chk("zero_in_ready2", 32'(tb_in_ready),  32'd1);
    chk("zero_valid2",    32'(tb_out_valid), 32'd0);

    // Back-pressure 0110
    tb_in = 4'b0110; tb_in_valid = 1'b1; tb_out_ready = 1'b0;
    step();
    tb_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 32'(tb_out_valid), 32'd1);
      chk("bp_hold_out",   32'(tb_out),       32'(BP_C0));
      chk("bp_hold_last",  32'(tb_last),      32'd0);
      step();
    end
    tb_out_ready = 1'b1;
    chk("bp_c0_out",  32'(tb_out),  32'(BP_C0));
    step();
    chk("bp_c1_out",  32'(tb_out),  32'(BP_C1));
    chk("bp_c1_last", 32'(tb_last), 32'd1);
    step();
    chk("bp_done_valid", 32'(tb_out_valid), 32'd0);

    // Reset mid-operation: 1111, two codes consumed, then reset
    tb_in = 4'b1111; tb_in_valid = 1'b1;
    step();
    tb_in_valid = 1'b0;
    step();
    step();
    chk("rm_midemit_valid", 32'(tb_out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid",    32'(tb_out_valid), 32'd0);
    chk("rm_in_ready", 32'(tb_in_ready),  32'd1);
    chk("rm_zero",     32'(tb_zero),      32'd0);
    chk("rm_out",      32'(tb_out),       32'd0);
    chk("rm_last",     32'(tb_last),      32'd0);
    tb_in = 4'b0010; tb_in_valid = 1'b1;
    step();
    tb_in_valid = 1'b0;
    chk("rm_next_out",  32'(tb_out),  32'd1);
    chk("rm_next_last", 32'(tb_last), 32'd1);
    step();
    chk("rm_next_done", 32'(tb_out_valid), 32'd0);
    step();
    chk("rm_no_leftover", 32'(tb_out_valid), 32'd0);

    // Input ignored while busy: 0101 then 1000 offered during EMIT
    tb_in = 4'b0101; tb_in_valid = 1'b1;
    step();
    tb_in = 4'b1000;
    chk("busy_in_ready", 32'(tb_in_ready), 32'd0);
    chk("busy_c0_out",   32'(tb_out),      32'(BZ_C0));
    chk("busy_c0_last",  32'(tb_last),     32'd0);
    step();
    chk("busy_in_ready2", 32'(tb_in_ready), 32'd0);
    chk("busy_c1_out",    32'(tb_out),      32'(BZ_C1));
    chk("busy_c1_last",   32'(tb_last),     32'd1);
    step();
    tb_in_valid = 1'b0;
    chk("busy_done_valid", 32'(tb_out_valid), 32'd0);
    chk("busy_done_ready", 32'(tb_in_ready),  32'd1);
    step();
    chk("busy_not_latched", 32'(tb_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule : tb_encoder_seq
`default_nettype wire
